// File: rtl/hci_tcdm_bank_ctrl.sv
// Memory-side controller for one TCDM bank: grants requests to a 1-cycle SRAM,
// returns responses one cycle later and runs test-and-set as a read then a 1s write.
module hci_tcdm_bank_ctrl #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned IW = 20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [AW-1:0]      add_i,
  input  logic               wen_i,
  input  logic               ts_i,
  input  logic [DW-1:0]      data_i,
  input  logic [DW/BW-1:0]   be_i,
  input  logic [IW-1:0]      id_i,
  output logic               r_valid_o,
  output logic [DW-1:0]      r_data_o,
  output logic [IW-1:0]      r_id_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  output logic [DW/BW-1:0]   mem_be_o,
  input  logic [DW-1:0]      mem_rdata_i
);

  typedef enum logic {IDLE, TS_WR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ts_addr_q, ts_addr_d;
  logic            r_valid_q, r_valid_d;
  logic            is_read_q, is_read_d;
  logic [IW-1:0]   r_id_q, r_id_d;
  logic [DW-1:0]   r_data_q, r_data_d;
  logic            grant;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && wen_i && ts_i) state_d = TS_WR;
      TS_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: gnt_o is kept free of any SRAM-side input
  always_comb begin
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = add_i;
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
    case (state_q)
      IDLE: begin
        gnt_o     = ~rst_i;
        mem_req_o = req_i & ~rst_i;
        mem_we_o  = ~wen_i;
      end
      TS_WR: begin
        mem_req_o   = ~rst_i;
        mem_we_o    = 1'b1;
        mem_addr_o  = ts_addr_q;
        mem_wdata_o = '1;
        mem_be_o    = '1;
      end
      default: ;
    endcase
  end

  assign grant = gnt_o & req_i;

  always_comb begin
    ts_addr_d = ts_addr_q;
    is_read_d = is_read_q;
    r_id_d    = r_id_q;
    r_valid_d = grant;
    if (grant) begin
      is_read_d = wen_i;
      r_id_d    = id_i;
      if (wen_i && ts_i) ts_addr_d = add_i;
    end
  end

  // Response data is taken straight from the SRAM in the response cycle and held afterwards
  always_comb begin
    r_valid_o = r_valid_q & ~rst_i;
    r_data_d  = r_data_q;
    if (r_valid_o) r_data_d = is_read_q ? mem_rdata_i : '0;
    r_data_o  = r_data_d;
    r_id_o    = r_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
      r_data_q  <= r_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ts_addr_q <= ts_addr_d;
    is_read_q <= is_read_d;
  end

endmodule
